// File: rtl/cc_alu_seq.sv
// cc_alu_seq: sequential ALU with single-cycle logic/arithmetic, bit-serial
// shifts, and iterative unsigned multiply/divide. Condition codes live in a
// registered flag set; outputs are active-low as on the original datapath.
//
// Handshake: start is a request that is taken (operands and opcode latched) on
// a rising edge only when the unit can accept -- idle with nothing pending,
// on the edge that completes a single-cycle op, or on the done edge of a
// multi-cycle op. A start seen at any other edge is dropped, not queued.
// done pulses for exactly one cycle on the edge the result registers.
`timescale 1ns/1ps
module cc_alu_seq #(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_SHAMT         = $clog2(DATAWIDTH_BUS)
) (
  input  logic                               CC_ALU_SEQ_CLOCK_50,
  input  logic                               CC_ALU_SEQ_RESET_InLow,
  input  logic                               CC_ALU_SEQ_start_InHigh,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALU_SEQ_selection_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_dataA_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_dataB_InBUS,
  output logic                               CC_ALU_SEQ_busy_OutHigh,
  output logic                               CC_ALU_SEQ_done_OutHigh,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_data_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_Y_OutBUS,
  output logic                               CC_ALU_SEQ_overflow_OutLow,
  output logic                               CC_ALU_SEQ_carry_OutLow,
  output logic                               CC_ALU_SEQ_negative_OutLow,
  output logic                               CC_ALU_SEQ_zero_OutLow,
  output logic                               CC_ALU_SEQ_setcc_OutHigh
);
  localparam int W  = DATAWIDTH_BUS;
  localparam int SW = DATAWIDTH_ALU_SELECTION;
  localparam int CW = DATAWIDTH_SHAMT + 1;

  typedef logic [SW-1:0] op_t;
  localparam op_t OP_SUBCC  = SW'(0);
  localparam op_t OP_ORCC   = SW'(1);
  localparam op_t OP_NORCC  = SW'(2);
  localparam op_t OP_ADDCC  = SW'(3);
  localparam op_t OP_ANDCC  = SW'(4);
  localparam op_t OP_AND    = SW'(5);
  localparam op_t OP_OR     = SW'(6);
  localparam op_t OP_NOR    = SW'(7);
  localparam op_t OP_ADD    = SW'(8);
  localparam op_t OP_SLL    = SW'(9);
  localparam op_t OP_SRL    = SW'(10);
  localparam op_t OP_SRA    = SW'(11);
  localparam op_t OP_UMULCC = SW'(12);
  localparam op_t OP_UDIVCC = SW'(13);
  localparam op_t OP_XOR    = SW'(14);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL, ST_DIV} state_t;

  state_t        state_q, state_d;
  logic          pend_q, pend_d;      // an accepted op waits in IDLE for decode
  op_t           op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;        // shift value / MUL low word / DIV quotient
  logic [W-1:0]  hi_q, hi_d;          // MUL high word / DIV partial remainder
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d, y_q, y_d;
  logic          n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d; // asserted-high inside
  logic          done_q, done_d, setcc_q, setcc_d;

  logic [DATAWIDTH_SHAMT-1:0] shamt;
  logic          is_shift, is_cc, can_accept;
  logic [W:0]    add_w, sub_w, mul_sum, div_sh, div_df;
  logic [W-1:0]  sc_res, shift_nx, mul_hi_nx, mul_lo_nx, div_rem_nx, div_quo_nx;
  logic          sc_c, sc_v, div_ge;

  assign shamt    = b_q[DATAWIDTH_SHAMT-1:0];
  assign is_shift = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);
  assign is_cc    = (op_q == OP_SUBCC) || (op_q == OP_ORCC) || (op_q == OP_NORCC) ||
                    (op_q == OP_ADDCC) || (op_q == OP_ANDCC);

  // Single-cycle result plus carry/overflow, from the latched operands
  always_comb begin
    add_w  = {1'b0, a_q} + {1'b0, b_q};
    sub_w  = {1'b0, a_q} - {1'b0, b_q};
    sc_res = a_q;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op_q)
      OP_SUBCC: begin
        sc_res = sub_w[W-1:0];
        sc_c   = sub_w[W];  // borrow: A < B unsigned
        sc_v   = (a_q[W-1] != b_q[W-1]) && (sub_w[W-1] != a_q[W-1]);
      end
      OP_ADDCC: begin
        sc_res = add_w[W-1:0];
        sc_c   = add_w[W];
        sc_v   = (a_q[W-1] == b_q[W-1]) && (add_w[W-1] != a_q[W-1]);
      end
      OP_ORCC, OP_OR:   sc_res = a_q | b_q;
      OP_NORCC, OP_NOR: sc_res = ~(a_q | b_q);
      OP_ANDCC, OP_AND: sc_res = a_q & b_q;
      OP_ADD:           sc_res = add_w[W-1:0];
      OP_XOR:           sc_res = a_q ^ b_q;
      default:          sc_res = a_q;  // PASS A, and shifts by zero
    endcase
  end

  // One iteration each of the shifter, shift-add multiplier and restoring divider
  always_comb begin
    case (op_q)
      OP_SLL:  shift_nx = {acc_q[W-2:0], 1'b0};
      OP_SRA:  shift_nx = {acc_q[W-1], acc_q[W-1:1]};
      default: shift_nx = {1'b0, acc_q[W-1:1]};
    endcase
    mul_sum    = {1'b0, hi_q} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    mul_hi_nx  = mul_sum[W:1];
    mul_lo_nx  = {mul_sum[0], acc_q[W-1:1]};
    div_sh     = {hi_q, acc_q[W-1]};
    // Compare rather than test the borrow so divide-by-zero yields all-ones
    div_ge     = (div_sh >= {1'b0, b_q});
    div_df     = div_sh - {1'b0, b_q};
    div_rem_nx = div_ge ? div_df[W-1:0] : div_sh[W-1:0];
    div_quo_nx = {acc_q[W-2:0], div_ge};
  end

  // Control FSM: decode the pending op, iterate, complete, accept next request
  always_comb begin
    state_d = state_q;  pend_d = pend_q;  op_d = op_q;
    a_d = a_q;  b_d = b_q;  acc_d = acc_q;  hi_d = hi_q;  cnt_d = cnt_q;
    data_d = data_q;  y_d = y_q;
    n_d = n_q;  z_d = z_q;  c_d = c_q;  v_d = v_q;
    done_d = 1'b0;  setcc_d = 1'b0;  can_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!pend_q) begin
          can_accept = 1'b1;
        end else begin
          pend_d = 1'b0;
          if (is_shift && (shamt != '0)) begin
            state_d = ST_SHIFT;  cnt_d = CW'(shamt);  acc_d = a_q;
          end else if (op_q == OP_UMULCC) begin
            state_d = ST_MUL;  cnt_d = CW'(W);  acc_d = a_q;  hi_d = '0;
          end else if (op_q == OP_UDIVCC) begin
            state_d = ST_DIV;  cnt_d = CW'(W);  acc_d = a_q;  hi_d = '0;
          end else begin
            data_d = sc_res;  done_d = 1'b1;  can_accept = 1'b1;
            if (is_cc) begin
              n_d = sc_res[W-1];  z_d = (sc_res == '0);  c_d = sc_c;  v_d = sc_v;
              setcc_d = 1'b1;
            end
          end
        end
      end
      ST_SHIFT: begin
        acc_d = shift_nx;  cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          data_d = shift_nx;  done_d = 1'b1;  state_d = ST_IDLE;  can_accept = 1'b1;
        end
      end
      ST_MUL: begin
        acc_d = mul_lo_nx;  hi_d = mul_hi_nx;  cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          data_d = mul_lo_nx;  y_d = mul_hi_nx;
          n_d = mul_lo_nx[W-1];  z_d = (mul_lo_nx == '0);
          c_d = 1'b0;  v_d = (mul_hi_nx != '0);
          done_d = 1'b1;  setcc_d = 1'b1;  state_d = ST_IDLE;  can_accept = 1'b1;
        end
      end
      ST_DIV: begin
        acc_d = div_quo_nx;  hi_d = div_rem_nx;  cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          data_d = div_quo_nx;  y_d = div_rem_nx;
          n_d = div_quo_nx[W-1];  z_d = (div_quo_nx == '0);
          c_d = 1'b0;  v_d = (b_q == '0);
          done_d = 1'b1;  setcc_d = 1'b1;  state_d = ST_IDLE;  can_accept = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (can_accept && CC_ALU_SEQ_start_InHigh) begin
      pend_d = 1'b1;
      op_d   = CC_ALU_SEQ_selection_InBUS;
      a_d    = CC_ALU_SEQ_dataA_InBUS;
      b_d    = CC_ALU_SEQ_dataB_InBUS;
    end
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge CC_ALU_SEQ_CLOCK_50 or negedge CC_ALU_SEQ_RESET_InLow) begin
    if (!CC_ALU_SEQ_RESET_InLow) begin
      state_q <= ST_IDLE;  pend_q <= 1'b0;  op_q <= '0;
      a_q <= '0;  b_q <= '0;  acc_q <= '0;  hi_q <= '0;  cnt_q <= '0;
      data_q <= '0;  y_q <= '0;
      n_q <= 1'b0;  z_q <= 1'b0;  c_q <= 1'b0;  v_q <= 1'b0;
      done_q <= 1'b0;  setcc_q <= 1'b0;
    end else begin
      state_q <= state_d;  pend_q <= pend_d;  op_q <= op_d;
      a_q <= a_d;  b_q <= b_d;  acc_q <= acc_d;  hi_q <= hi_d;  cnt_q <= cnt_d;
      data_q <= data_d;  y_q <= y_d;
      n_q <= n_d;  z_q <= z_d;  c_q <= c_d;  v_q <= v_d;
      done_q <= done_d;  setcc_q <= setcc_d;
    end
  end

  assign CC_ALU_SEQ_busy_OutHigh    = (state_q != ST_IDLE);
  assign CC_ALU_SEQ_done_OutHigh    = done_q;
  assign CC_ALU_SEQ_setcc_OutHigh   = setcc_q;
  assign CC_ALU_SEQ_data_OutBUS     = data_q;
  assign CC_ALU_SEQ_Y_OutBUS        = y_q;
  assign CC_ALU_SEQ_negative_OutLow = ~n_q;
  assign CC_ALU_SEQ_zero_OutLow     = ~z_q;
  assign CC_ALU_SEQ_carry_OutLow    = ~c_q;
  assign CC_ALU_SEQ_overflow_OutLow = ~v_q;
endmodule

// File: tb/tb_cc_alu_seq.sv
// Testbench for cc_alu_seq: directed cases plus randomized ops, checked
// against an arithmetic reference model of the ALU.
`timescale 1ns/1ps
module tb_cc_alu_seq;
  localparam int W   = 32;
  localparam int SHW = $clog2(W);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  logic         start;
  logic [3:0]   sel;
  logic [W-1:0] da, db;
  logic         busy_o, done_o, setcc_o, ovf_o, cry_o, neg_o, zro_o;
  logic [W-1:0] data_o, y_o;

  cc_alu_seq #(.DATAWIDTH_BUS(W), .DATAWIDTH_ALU_SELECTION(4)) dut (
    .CC_ALU_SEQ_CLOCK_50        (clk),
    .CC_ALU_SEQ_RESET_InLow     (rst_n),
    .CC_ALU_SEQ_start_InHigh    (start),
    .CC_ALU_SEQ_selection_InBUS (sel),
    .CC_ALU_SEQ_dataA_InBUS     (da),
    .CC_ALU_SEQ_dataB_InBUS     (db),
    .CC_ALU_SEQ_busy_OutHigh    (busy_o),
    .CC_ALU_SEQ_done_OutHigh    (done_o),
    .CC_ALU_SEQ_data_OutBUS     (data_o),
    .CC_ALU_SEQ_Y_OutBUS        (y_o),
    .CC_ALU_SEQ_overflow_OutLow (ovf_o),
    .CC_ALU_SEQ_carry_OutLow    (cry_o),
    .CC_ALU_SEQ_negative_OutLow (neg_o),
    .CC_ALU_SEQ_zero_OutLow     (zro_o),
    .CC_ALU_SEQ_setcc_OutHigh   (setcc_o)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_data, exp_y;
  bit exp_n, exp_z, exp_c, exp_v, exp_setcc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_result(input string tag);
    chk({tag, ".data"}, data_o, exp_data);
    chk({tag, ".y"}, y_o, exp_y);
    chk({tag, ".n_l"}, neg_o, !exp_n);
    chk({tag, ".z_l"}, zro_o, !exp_z);
    chk({tag, ".c_l"}, cry_o, !exp_c);
    chk({tag, ".v_l"}, ovf_o, !exp_v);
  endtask

  task automatic model_reset();
    exp_data = '0; exp_y = '0;
    exp_n = 0; exp_z = 0; exp_c = 0; exp_v = 0; exp_setcc = 0;
  endtask

  // Reference model: what the op produces, and how many edges it takes
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    logic [2*W-1:0] wide;
    logic [W:0]     s;
    logic [W-1:0]   r;
    int             sh;
    bit             cc, c, v;
    sh = int'(b[SHW-1:0]);
    lat = 1; cc = 0; c = 0; v = 0; r = a;
    case (op)
      4'd0:  begin r = a - b; c = (a < b); v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); cc = 1; end
      4'd1:  begin r = a | b; cc = 1; end
      4'd2:  begin r = ~(a | b); cc = 1; end
      4'd3:  begin
               s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
               v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); cc = 1;
             end
      4'd4:  begin r = a & b; cc = 1; end
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = ~(a | b);
      4'd8:  r = a + b;
      4'd9:  begin r = a << sh; lat = 1 + sh; end
      4'd10: begin r = a >> sh; lat = 1 + sh; end
      4'd11: begin r = $signed(a) >>> sh; lat = 1 + sh; end
      4'd12: begin
               wide = {{W{1'b0}}, a} * {{W{1'b0}}, b};
               r = wide[W-1:0]; exp_y = wide[2*W-1:W]; v = (exp_y != '0);
               cc = 1; lat = W + 1;
             end
      4'd13: begin
               if (b == '0) begin r = '1; exp_y = a; v = 1; end
               else begin r = a / b; exp_y = a % b; end
               cc = 1; lat = W + 1;
             end
      4'd14: r = a ^ b;
      default: r = a;
    endcase
    exp_data = r;
    exp_setcc = cc;
    if (cc) begin
      exp_n = r[W-1]; exp_z = (r == '0); exp_c = c; exp_v = v;
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rnd_single_op();
    int r;
    r = $urandom_range(0, 10);
    if (r == 9) return 4'd14;
    if (r == 10) return 4'd15;
    return 4'(r);
  endfunction

  // driver: issue one op, track done/busy each edge, optionally chain a
  // single-cycle op on the done edge, and pulse a stray start at edge pulse_k
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int pulse_k, input bit chain);
    int lat, lat2;
    logic [3:0] op2;
    logic [W-1:0] a2, b2;
    op2 = rnd_single_op(); a2 = rnd_val(); b2 = rnd_val();
    @(negedge clk);
    start = 1'b1; sel = op; da = a; db = b;
    model(op, a, b, lat);
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (chain && k == lat) begin
        start = 1'b1; sel = op2; da = a2; db = b2;
      end else begin
        start = (k == pulse_k) && (k < lat);
        sel = 4'($urandom_range(0, 15)); da = $urandom; db = $urandom;
      end
      @(posedge clk); #1;
      chk($sformatf("op%0d.done@%0d", op, k), done_o, (k == lat));
      chk($sformatf("op%0d.busy@%0d", op, k), busy_o, (lat > 1 && k < lat));
      if (k == lat) begin
        chk($sformatf("op%0d.setcc", op), setcc_o, exp_setcc);
        chk_result($sformatf("op%0d", op));
      end
    end
    if (chain) begin
      model(op2, a2, b2, lat2);
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("chain%0d.done", op2), done_o, 1'b1);
      chk($sformatf("chain%0d.busy", op2), busy_o, 1'b0);
      chk($sformatf("chain%0d.setcc", op2), setcc_o, exp_setcc);
      chk_result($sformatf("chain%0d", op2));
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("fall.done", done_o, 1'b0);
    chk("fall.setcc", setcc_o, 1'b0);
    chk("hold.data", data_o, exp_data);
  endtask

  // driver: a burst of single-cycle ops with start held high every cycle
  task automatic stream(input int n);
    logic [3:0]   ops[$];
    logic [W-1:0] as[$], bs[$];
    logic [3:0]   o;
    logic [W-1:0] a, b;
    int lat;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i < n) begin
        o = rnd_single_op(); a = rnd_val(); b = rnd_val();
        ops.push_back(o); as.push_back(a); bs.push_back(b);
        start = 1'b1; sel = o; da = a; db = b;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (i > 0) begin
        model(ops.pop_front(), as.pop_front(), bs.pop_front(), lat);
        chk("stream.done", done_o, 1'b1);
        chk("stream.busy", busy_o, 1'b0);
        chk("stream.setcc", setcc_o, exp_setcc);
        chk_result("stream");
      end
    end
    @(posedge clk); #1;
    chk("stream.fall", done_o, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"}, busy_o, 1'b0);
    chk({tag, ".done"}, done_o, 1'b0);
    chk({tag, ".setcc"}, setcc_o, 1'b0);
    chk_result(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int pk;
    logic [3:0] op;
    logic [W-1:0] a, b;
    rst_n = 1'b0; start = 1'b0; sel = '0; da = '0; db = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;

    // directed cases
    do_op(4'd3, 32'h7FFF_FFFF, 32'h1, 0, 0);
    do_op(4'd0, 32'd5, 32'd5, 0, 0);
    do_op(4'd0, 32'd3, 32'd5, 0, 0);
    do_op(4'd5, 32'd0, 32'd0, 0, 0);
    do_op(4'd11, 32'h8000_0000, 32'd4, 2, 0);
    do_op(4'd9, 32'hA5A5_1234, 32'h20, 0, 0);
    do_op(4'd10, 32'hF0, 32'd4, 0, 0);
    do_op(4'd12, 32'h0001_0000, 32'h0001_0000, 9, 0);
    do_op(4'd13, 32'd100, 32'd7, 5, 0);
    do_op(4'd13, 32'd9, 32'd0, 0, 1);

    // reset in the middle of a divide
    @(negedge clk); start = 1'b1; sel = 4'd13; da = 32'd100; db = 32'd7;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (13) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("midreset");
    repeat (2) begin
      @(posedge clk); #1;
      chk("midreset.nodone", done_o, 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      chk("postreset.nodone", done_o, 1'b0);
    end
    do_op(4'd8, 32'd2, 32'd3, 0, 0);

    // back-to-back single-cycle ops
    stream(10);

    // randomized ops
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = rnd_val();
      b = rnd_val();
      if (op == 4'd13 && $urandom_range(0, 4) == 0) b = '0;
      pk = $urandom_range(0, 40);
      do_op(op, a, b, pk, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cc_alu_seq.md
# cc_alu_seq

Parametrised sequential ALU that replaces the purely combinational datapath ALU. It executes single-cycle logic and arithmetic, bit-serial variable shifts, and iterative unsigned multiply/divide under a start/busy/done handshake. Condition codes are held in a registered PSR-style flag set. It sits between the register file read ports and the result bus, and the control unit sequences it via `start` and `done`.

## Interface
- `DATAWIDTH_BUS`, 32, operand/result width; legal range 8..64.
- `DATAWIDTH_ALU_SELECTION`, 4, opcode width.
- `DATAWIDTH_SHAMT`, `$clog2(DATAWIDTH_BUS)`, shift-amount width taken from `B[DATAWIDTH_SHAMT-1:0]`.

Ports:
- `CC_ALU_SEQ_CLOCK_50`  in  1  system clock; all state changes on the rising edge.
- `CC_ALU_SEQ_RESET_InLow`  in  1  reset, asynchronous and active-low.
- `CC_ALU_SEQ_start_InHigh`  in  1  operation request; sampled only when idle.
- `CC_ALU_SEQ_selection_InBUS`  in  `DATAWIDTH_ALU_SELECTION`  opcode.
- `CC_ALU_SEQ_dataA_InBUS`  in  `DATAWIDTH_BUS`  operand A.
- `CC_ALU_SEQ_dataB_InBUS`  in  `DATAWIDTH_BUS`  operand B.
- `CC_ALU_SEQ_busy_OutHigh`  out  1  operation in progress.
- `CC_ALU_SEQ_done_OutHigh`  out  1  one-cycle pulse; the result is valid.
- `CC_ALU_SEQ_data_OutBUS`  out  `DATAWIDTH_BUS`  registered result.
- `CC_ALU_SEQ_Y_OutBUS`  out  `DATAWIDTH_BUS`  MUL high word or DIV remainder.
- `CC_ALU_SEQ_overflow_OutLow`, `CC_ALU_SEQ_carry_OutLow`, `CC_ALU_SEQ_negative_OutLow`, `CC_ALU_SEQ_zero_OutLow`  out  1 each  registered flags, active-low.
- `CC_ALU_SEQ_setcc_OutHigh`  out  1  pulses with `done` when the flags were updated.

## Operation
- Opcodes:
  - 0000 SUBCC, 0001 ORCC, 0010 NORCC, 0011 ADDCC, 0100 ANDCC.
  - 0101 AND, 0110 OR, 0111 NOR, 1000 ADD.
  - 1001 SLL, 1010 SRL, 1011 SRA.
  - 1100 UMULCC, 1101 UDIVCC, 1110 XOR, 1111 PASS A.
- Only the CC opcodes (0000–0100, 1100, 1101) update the flags. All other opcodes leave the flags unchanged.
- Operands and opcode are latched at the accepting edge. Later input changes have no effect until the next accept.
- FSM states: IDLE, SHIFT, MUL, DIV.
  - IDLE + start: a single-cycle opcode writes the result and returns to IDLE with `done` set.
  - A shift opcode loads a count equal to the shift amount. Count 0 completes immediately, as a single-cycle op. Otherwise the FSM goes to SHIFT.
  - SHIFT performs one bit per cycle and decrements the count; it completes when the count reaches 0.
  - MUL uses shift-add and DIV uses restoring division, each for exactly `DATAWIDTH_BUS` iterations, then completes.
- SRA replicates the MSB. SLL and SRL fill with 0.
- Flag rules (asserted means 0):
  - N = result MSB; Z = result all-zero.
  - ADDCC: C = carry out of the MSB; V = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUBCC: C = borrow (A < B unsigned); V = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - Logic CC ops: C and V deasserted.
  - UMULCC: N and Z from the low word; V asserted iff the high word is nonzero; C deasserted.
  - UDIVCC: C deasserted. V asserted only on divide by zero, which gives quotient all-ones and `Y` = A.
- `Y` is written only by UMULCC and UDIVCC; all other ops leave it unchanged.
- `start` while busy is ignored. It is neither queued nor allowed to corrupt the operation in flight.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `setcc`=0, `data`=0, `Y`=0, all four flags=1 (deasserted).
- Reset mid-operation aborts immediately to those values, and no `done` is emitted.
- Latency L, counted from the accepting edge N to the edge that registers the result (edge N+L):
  - Single-cycle ops: L=1.
  - Shifts: L = 1 + amount.
  - UMULCC and UDIVCC: L = 1 + `DATAWIDTH_BUS`.
- `done`, `setcc`, result, `Y` and flags all update together at edge N+L. `done` and `setcc` fall at N+L+1.
- `busy` is 1 from edge N+1 through edge N+L for multi-cycle ops, and is never 1 for L=1.
- Back-to-back: a new `start` may be accepted at edge N+L (the done edge) for multi-cycle ops, and at N+1 for single-cycle ops. This gives throughput of one single-cycle op per clock.
- The result and flags hold their values until the next completing operation.

## Test plan
- ADDCC with A=0x7FFFFFFF, B=0x00000001 -> `data`=0x80000000 one edge after accept; N=0, V=0, C=1, Z=1; `done` and `setcc` each pulse exactly one cycle.
- SUBCC 5-5 -> 0 with Z=0, C=1. Then SUBCC 3-5 -> 0xFFFFFFFE with N=0, C=0, V=1. Then AND 0 & 0 -> flags unchanged from the previous op and `setcc`=0.
- SRA A=0x80000000, B=4 -> 0xF8000000 at latency 5 with `busy` high for 4 cycles. SLL with B=0x20 (amount 0) -> A unchanged at latency 1. SRL 0xF0 by 4 -> 0x0F.
- UMULCC 0x00010000 × 0x00010000 -> `data`=0, `Y`=1, Z=0, V=0 at latency 33. A `start` pulsed at cycle 10 is ignored and the result is unaffected.
- UDIVCC 100/7 -> `data`=14, `Y`=2, V=1. UDIVCC 9/0 -> `data`=0xFFFFFFFF, `Y`=9, V=0.
- Drive reset low mid-UDIVCC (iteration 12) -> all outputs are at reset values asynchronously and no `done` is emitted. A new ADD 2+3 after reset release -> 5 at latency 1.
